// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ifq_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          PC_W             = 32;
    localparam int          ENTRY_W          = PC_W + INSTR_W;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO; head is held in a register so data_o/valid_o
// never see a combinational path from push/pop/flush.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        do_push  = push_i && !flush_i;
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_d   = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
        // The new head is the word being written only when it lands in the slot the head moves to.
        if (count_d != '0) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? data_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetches instructions over a req/ack memory port into a small FWFT queue
// feeding IF/ID; a branch redirect flushes the queue and restarts fetch.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DATA_W   = INSTR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    input  logic                         deq_i,
    output logic                         mem_req_o,
    output logic [31:0]                  mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [DATA_W-1:0]            mem_data_i,
    output logic [DATA_W-1:0]            instr_o,
    output logic [31:0]                  pc4_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH+1);

    ifq_state_e          state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic                req_q, req_d;
    logic [31:0]         addr_q, addr_d;
    logic                push, pop;
    logic [31:0]         redirect_pc;
    logic [CNT_W-1:0]    fifo_count, count_after;
    logic                fifo_valid;
    logic [PC_W+DATA_W-1:0] head;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        push        = 1'b0;
        pop         = deq_i && fifo_valid;
        redirect_pc = redirect_pc_i & ~32'd3;
        count_after = fifo_count + CNT_W'(1) - CNT_W'(pop);
        unique case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end
                if (redirect_i || (fifo_count < CNT_W'(DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_d;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A redirect without ack must keep the old request up until memory answers.
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_ack_i) begin
                        addr_d = redirect_pc;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (count_after < CNT_W'(DEPTH)) begin
                        addr_d = fetch_pc_d;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end
                if (mem_ack_i) begin
                    addr_d  = fetch_pc_d;
                    state_d = REQ;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  ({fetch_pc_q + 32'd4, mem_data_i}),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign instr_o    = head[DATA_W-1:0];
    assign pc4_o      = head[PC_W+DATA_W-1:DATA_W];
    assign valid_o    = fifo_valid;
    assign count_o    = fifo_count;

endmodule
